syscall_io_unit: RTL and testbench

//  - Responder side of the CPU SYSCALL handshake: samples runio, drives iobusy, returns io_result to the ACC IO mux.
//  - Executes HALT/READ/WRITE against external valid/ready byte-stream ports (host console).
//  - Sits beside the controller; sysno comes from ACC, arg from DR.

---
 rtl/sextium_io_pkg.sv | 19 +
 rtl/io_timeout_counter.sv | 38 +++
 rtl/syscall_io_unit.sv | 145 ++++++++++++++
 tb/tb_syscall_io_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sextium_io_pkg.sv
// Shared definitions for the SYSCALL responder: syscall numbers and FSM state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sextium_io_pkg;

    // Syscall numbers as presented on ACC; compared against the full data width
    localparam int unsigned SYS_HALT  = 0;
    localparam int unsigned SYS_READ  = 1;
    localparam int unsigned SYS_WRITE = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_HALT  = 3'd4
    } io_state_t;

endpackage

// File: rtl/io_timeout_counter.sv
// Wait-cycle counter for stream handshakes; flags expiry on the LIMIT-th enabled edge.
// Latency: o_expired is combinational from the count, so the FSM acts on the expiring edge itself.
// Backpressure: none; LIMIT=0 never expires (wait forever).
//
// Ports:
//   i_clock, i_reset : clock, async active-high reset
//   i_clear          : hold count at zero (while not waiting)
//   i_enable         : count one waiting edge
//   o_expired        : this edge is the LIMIT-th waiting edge
module io_timeout_counter #(
    parameter int unsigned LIMIT = 0
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned     CW   = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW-1:0]   LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

    logic [CW-1:0] r_count;

    // Count holds LIMIT-1 during the final waiting cycle, so expiry is seen on that edge
    assign o_expired = (LIMIT > 0) && (r_count == LAST);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/syscall_io_unit.sv
// SYSCALL responder: runs HALT/READ/WRITE against host valid/ready byte streams for the CPU controller.
// Latency: request edge to iobusy low is 2 edges minimum; READ/WRITE add the host handshake wait.
// Backpressure: in_ready/out_valid held until the host handshakes or the optional timeout expires.
//
// Ports:
//   i_clock, i_reset         : clock, async active-high reset
//   i_runio, i_sysno, i_arg  : controller request/hold, syscall number (ACC), argument (DR)
//   o_iobusy, o_io_result    : busy flag and result back to the controller
//   o_halted, o_io_error     : sticky HALT and error indicators
//   i_in_valid/i_in_data/o_in_ready    : host input stream (READ)
//   o_out_valid/o_out_data/i_out_ready : host output stream (WRITE)
module syscall_io_unit
    import sextium_io_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_runio,
    input  logic [WIDTH-1:0] i_sysno,
    input  logic [WIDTH-1:0] i_arg,
    output logic             o_iobusy,
    output logic [WIDTH-1:0] o_io_result,
    output logic             o_halted,
    output logic             o_io_error,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output logic [WIDTH-1:0] o_out_data,
    input  logic             i_out_ready
);

    io_state_t        r_state;
    logic             r_iobusy;
    logic             r_halted;
    logic             r_io_error;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_io_result;
    logic [WIDTH-1:0] r_out_data;

    logic w_waiting;
    logic w_expired;
    logic w_rd_hs;
    logic w_wr_hs;

    assign w_waiting = (r_state == ST_READ) || (r_state == ST_WRITE);
    assign w_rd_hs   = (r_state == ST_READ)  && i_in_valid  && r_in_ready;
    assign w_wr_hs   = (r_state == ST_WRITE) && r_out_valid && i_out_ready;

    // Timer sits at zero outside READ/WRITE, so every stream wait starts from a clean count
    io_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_clear   (!w_waiting),
        .i_enable  (w_waiting),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_iobusy    <= 1'b0;
            r_halted    <= 1'b0;
            r_io_error  <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_io_result <= '0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // runio is only a new request here; while busy it is just the controller holding
                    if (i_runio) begin
                        r_iobusy   <= 1'b1;
                        r_out_data <= i_arg;
                        if (i_sysno == WIDTH'(SYS_HALT)) begin
                            r_halted <= 1'b1;
                            r_state  <= ST_HALT;
                        end else if (i_sysno == WIDTH'(SYS_READ)) begin
                            r_in_ready <= 1'b1;
                            r_state    <= ST_READ;
                        end else if (i_sysno == WIDTH'(SYS_WRITE)) begin
                            r_out_valid <= 1'b1;
                            r_state     <= ST_WRITE;
                        end else begin
                            r_io_result <= '0;
                            r_io_error  <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
                end
                ST_READ: begin
                    // A handshake landing on the expiry edge takes priority over the timeout
                    if (w_rd_hs) begin
                        r_io_result <= i_in_data;
                        r_in_ready  <= 1'b0;
                        r_state     <= ST_DONE;
                    end else if (w_expired) begin
                        r_io_result <= '1;
                        r_io_error  <= 1'b1;
                        r_in_ready  <= 1'b0;
                        r_state     <= ST_DONE;
                    end
                end
                ST_WRITE: begin
                    if (w_wr_hs) begin
                        r_io_result <= r_out_data;
                        r_out_valid <= 1'b0;
                        r_state     <= ST_DONE;
                    end else if (w_expired) begin
                        r_io_result <= '1;
                        r_io_error  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_iobusy <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                ST_HALT: begin
                    // CPU stays parked in IOWAIT; only reset leaves this state
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_iobusy    = r_iobusy;
    assign o_io_result = r_io_result;
    assign o_halted    = r_halted;
    assign o_io_error  = r_io_error;
    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_syscall_io_unit.sv
// Bench for syscall_io_unit: table of syscalls plus hand sequences for HALT, timeout and async reset.
// Latency: n/a.
// Backpressure: host side driven with per-vector handshake delays.
module tb_syscall_io_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         runio = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] sysno = '0;
    logic [W-1:0] arg = '0;
    logic [W-1:0] in_data = '0;

    // u_dut: waits forever; u_to: TIMEOUT_CYCLES=4
    logic         a_iobusy, a_halted, a_io_error, a_in_ready, a_out_valid;
    logic [W-1:0] a_io_result, a_out_data;
    logic         b_iobusy, b_halted, b_io_error, b_in_ready, b_out_valid;
    logic [W-1:0] b_io_result, b_out_data;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    syscall_io_unit #(.WIDTH(W), .TIMEOUT_CYCLES(0)) u_dut (
        .i_clock(clk), .i_reset(rst), .i_runio(runio), .i_sysno(sysno), .i_arg(arg),
        .o_iobusy(a_iobusy), .o_io_result(a_io_result), .o_halted(a_halted), .o_io_error(a_io_error),
        .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(a_in_ready),
        .o_out_valid(a_out_valid), .o_out_data(a_out_data), .i_out_ready(out_ready)
    );

    syscall_io_unit #(.WIDTH(W), .TIMEOUT_CYCLES(4)) u_to (
        .i_clock(clk), .i_reset(rst), .i_runio(runio), .i_sysno(sysno), .i_arg(arg),
        .o_iobusy(b_iobusy), .o_io_result(b_io_result), .o_halted(b_halted), .o_io_error(b_io_error),
        .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(b_in_ready),
        .o_out_valid(b_out_valid), .o_out_data(b_out_data), .i_out_ready(out_ready)
    );

    typedef struct {
        logic [W-1:0] sysno;
        logic [W-1:0] arg;
        logic [W-1:0] din;
        int           dly;      // waiting cycles before host asserts valid/ready
        logic [W-1:0] exp_res;
        logic         exp_err;
        int           exp_lat;  // request edge to iobusy low, in edges
        int           exp_act;  // cycles with in_ready/out_valid high
    } vec_t;

    vec_t vecs[8];
    vec_t vfinal;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Acts as controller (runio held while busy) and host (valid/ready after v.dly cycles)
    task automatic run_vec(input vec_t v, input int idx);
        int edges;
        int act;
        bit data_ok;
        @(negedge clk);
        runio = 1'b1; sysno = v.sysno; arg = v.arg; in_data = v.din;
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        edges = 1; act = 0; data_ok = 1'b1;
        while (edges < 200) begin
            @(negedge clk);
            if (!a_iobusy) break;
            if (a_in_ready) act++;
            if (a_out_valid) begin
                act++;
                if (a_out_data !== v.arg) data_ok = 1'b0;
            end
            in_valid  = (v.sysno == 16'd1) && (edges - 1 >= v.dly);
            out_ready = (v.sysno == 16'd2) && (edges - 1 >= v.dly);
            @(posedge clk);
            edges++;
        end
        runio = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk($sformatf("v%0d_latency", idx), edges, v.exp_lat);
        chk($sformatf("v%0d_io_result", idx), a_io_result, v.exp_res);
        chk($sformatf("v%0d_io_error", idx), a_io_error, v.exp_err);
        chk($sformatf("v%0d_stream_cycles", idx), act, v.exp_act);
        chk($sformatf("v%0d_out_data_stable", idx), data_ok, 1);
        chk($sformatf("v%0d_idle_in_ready", idx), a_in_ready, 0);
        chk($sformatf("v%0d_idle_out_valid", idx), a_out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int busy_bad;

        //            sysno     arg       din       dly exp_res   err   lat act
        vecs[0] = '{16'h0002, 16'h0041, 16'h0000, 0, 16'h0041, 1'b0, 3, 1};
        vecs[1] = '{16'h0001, 16'h0000, 16'h1234, 5, 16'h1234, 1'b0, 8, 6};
        vecs[2] = '{16'h0002, 16'hBEEF, 16'h0000, 2, 16'hBEEF, 1'b0, 5, 3};
        vecs[3] = '{16'h0007, 16'h1111, 16'h0000, 0, 16'h0000, 1'b1, 2, 0};
        vecs[4] = '{16'h0002, 16'h7E57, 16'h0000, 0, 16'h7E57, 1'b1, 3, 1};
        vecs[5] = '{16'h0101, 16'h2222, 16'h0000, 0, 16'h0000, 1'b1, 2, 0};
        vecs[6] = '{16'h0001, 16'h0000, 16'hA5A5, 0, 16'hA5A5, 1'b1, 3, 1};
        vecs[7] = '{16'hFFFF, 16'h3333, 16'h0000, 0, 16'h0000, 1'b1, 2, 0};
        vfinal  = '{16'h0002, 16'h1357, 16'h0000, 1, 16'h1357, 1'b0, 4, 2};

        // Reset state
        #12;
        chk("rst_iobusy", a_iobusy, 0);
        chk("rst_halted", a_halted, 0);
        chk("rst_io_error", a_io_error, 0);
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_io_result", a_io_result, 0);
        chk("rst_out_data", a_out_data, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // HALT: busy forever regardless of runio, cleared only by reset
        @(negedge clk);
        runio = 1'b1; sysno = 16'h0000; arg = 16'h0000;
        @(posedge clk);
        busy_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_iobusy !== 1'b1) busy_bad++;
            runio = 1'($urandom_range(0, 1));
        end
        chk("halt_busy_drops", busy_bad, 0);
        chk("halt_halted", a_halted, 1);
        #2 rst = 1'b1;
        #1;
        chk("halt_rst_iobusy", a_iobusy, 0);
        chk("halt_rst_halted", a_halted, 0);
        chk("halt_rst_io_error", a_io_error, 0);
        @(negedge clk);
        rst = 1'b0; runio = 1'b0;

        // Timeout instance: handshake on the expiry edge wins
        @(negedge clk);
        runio = 1'b1; sysno = 16'h0001; in_data = 16'h5A5A; in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("to_hs_ready_before_expiry", b_in_ready, 1);
        in_valid = 1'b1;
        @(negedge clk);
        chk("to_hs_io_result", b_io_result, 16'h5A5A);
        chk("to_hs_io_error", b_io_error, 0);
        chk("to_hs_iobusy", b_iobusy, 1);
        @(negedge clk);
        chk("to_hs_iobusy_low", b_iobusy, 0);
        runio = 1'b0; in_valid = 1'b0;

        // Timeout instance: no input at all, expires after 4 waiting edges
        @(negedge clk);
        runio = 1'b1; sysno = 16'h0001; in_data = 16'h0000; in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("to_ready_edge4", b_in_ready, 1);
        chk("to_error_edge4", b_io_error, 0);
        @(negedge clk);
        chk("to_in_ready", b_in_ready, 0);
        chk("to_io_result", b_io_result, 16'hFFFF);
        chk("to_io_error", b_io_error, 1);
        chk("to_iobusy", b_iobusy, 1);
        @(negedge clk);
        chk("to_iobusy_low", b_iobusy, 0);
        runio = 1'b0;

        // Reset mid-WRITE with host stalled: outputs drop without a clock edge
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        runio = 1'b1; sysno = 16'h0002; arg = 16'hC0DE; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("mw_out_valid", a_out_valid, 1);
        chk("mw_out_data", a_out_data, 16'hC0DE);
        #2 rst = 1'b1;
        #1;
        chk("mw_rst_out_valid", a_out_valid, 0);
        chk("mw_rst_iobusy", a_iobusy, 0);
        chk("mw_rst_out_data", a_out_data, 0);
        @(negedge clk);
        rst = 1'b0; runio = 1'b0;
        repeat (2) @(negedge clk);
        chk("mw_idle_iobusy", a_iobusy, 0);
        chk("mw_idle_out_valid", a_out_valid, 0);
        run_vec(vfinal, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
